// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and data_ram port A.
//   Port 0 (CPU MEM stage):   req0, wen0, addr0, wdata0 -> gnt0, rvalid0, rdata0
//   Port 1 (debug/display):   req1, wen1, addr1, wdata1 -> gnt1, rvalid1, rdata1
//   RAM port A:               ram_wen, ram_addr, ram_wdata -> ram_rdata
// slave  : arbiter view
// master : requester/RAM environment view
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req0;
  logic [3:0]        wen0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [31:0]       rdata0;

  logic              req1;
  logic [3:0]        wen1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [31:0]       rdata1;

  logic [3:0]        ram_wen;
  logic [7:0]        ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req0, wen0, addr0, wdata0,
    input  req1, wen1, addr1, wdata1,
    input  ram_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output req0, wen0, addr0, wdata0,
    output req1, wen1, addr1, wdata1,
    output ram_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port synchronous data RAM.
// Fixed priority to the CPU (port 0); the debug port (port 1) is forced to win
// after STARVE_LIMIT consecutive denied cycles. Read data returns one cycle
// after the grant, steered to the port that issued the read.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   bus          requester/RAM bundle (dmem_arbiter_if.slave)
//   conflict_cnt saturating count of cycles with both requests pending
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            resp_vld;
  logic            resp_id;

  logic force1;
  logic gnt0_c;
  logic gnt1_c;
  logic rd_fire_c;

  // Grant: port 1 wins when alone or when starved; grants are held low in reset.
  always_comb begin
    force1 = (starve_cnt == SC_W'(STARVE_LIMIT));
    gnt1_c = !reset && bus.req1 && (force1 || !bus.req0);
    gnt0_c = !reset && bus.req0 && !gnt1_c;
  end

  assign bus.gnt0 = gnt0_c;
  assign bus.gnt1 = gnt1_c;

  // RAM drive mux: the granted port's access goes straight to the RAM this cycle.
  always_comb begin
    bus.ram_wen   = 4'h0;
    bus.ram_addr  = 8'h00;
    bus.ram_wdata = 32'h0;
    rd_fire_c     = 1'b0;
    if (gnt1_c) begin
      bus.ram_wen   = bus.wen1;
      bus.ram_addr  = bus.addr1[9:2];
      bus.ram_wdata = bus.wdata1;
      rd_fire_c     = (bus.wen1 == 4'h0);
    end else if (gnt0_c) begin
      bus.ram_wen   = bus.wen0;
      bus.ram_addr  = bus.addr0[9:2];
      bus.ram_wdata = bus.wdata0;
      rd_fire_c     = (bus.wen0 == 4'h0);
    end
  end

  // Starvation, response tag and conflict counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt   <= '0;
      resp_vld     <= 1'b0;
      resp_id      <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (!bus.req1 || gnt1_c) begin
        starve_cnt <= '0;
      end else if (!force1) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end

      resp_vld <= rd_fire_c;
      if (rd_fire_c) begin
        resp_id <= gnt1_c;
      end

      if (bus.req0 && bus.req1 && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  // Read response: RAM output is passed through to the tagged port only.
  always_comb begin
    bus.rvalid0 = resp_vld && !resp_id;
    bus.rvalid1 = resp_vld && resp_id;
    bus.rdata0  = bus.rvalid0 ? bus.ram_rdata : 32'h0;
    bus.rdata1  = bus.rvalid1 ? bus.ram_rdata : 32'h0;
  end

  // Byte-offset and upper address bits do not select a RAM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr0[ADDR_W-1:10], bus.addr0[1:0],
                              bus.addr1[ADDR_W-1:10], bus.addr1[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-first synchronous RAM model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] conflict_cnt;

  int n_checks;
  int n_errors;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, read-first, byte write enables, 1-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.ram_wen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Requesters must hold addr/wen while waiting for a grant.
  assert property (@(posedge clk) disable iff (reset)
    (bus.req0 && !bus.gnt0) |=> (!bus.req0 || ($stable(bus.addr0) && $stable(bus.wen0))));
  assert property (@(posedge clk) disable iff (reset)
    (bus.req1 && !bus.gnt1) |=> (!bus.req1 || ($stable(bus.addr1) && $stable(bus.wen1))));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.wen0 = 4'h0; bus.addr0 = '0; bus.wdata0 = 32'h0;
    bus.req1 = 1'b0; bus.wen1 = 4'h0; bus.addr1 = '0; bus.wdata1 = 32'h0;
  endtask

  // Debug-port full-word write; called and returns at a falling edge.
  task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
    bus.req1 = 1'b1; bus.wen1 = 4'hF; bus.addr1 = addr; bus.wdata1 = data;
    #1;
    check("wr1_gnt1", 32'(bus.gnt1), 32'd1);
    check("wr1_ram_wen", 32'(bus.ram_wen), 32'hF);
    step();
    bus.req1 = 1'b0; bus.wen1 = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    clear_inputs();
    bus.ram_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Preload RAM through the debug port
    wr1(32'h10, 32'hDEADBEEF);
    wr1(32'h40, 32'hA0A0A0A0);
    wr1(32'h44, 32'hB1B1B1B1);
    wr1(32'h48, 32'hC2C2C2C2);

    // Port 0 only read
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.wen0 = 4'h0;
    #1;
    check("p0_gnt0", 32'(bus.gnt0), 32'd1);
    check("p0_gnt1", 32'(bus.gnt1), 32'd0);
    check("p0_ram_addr", 32'(bus.ram_addr), 32'd4);
    check("p0_ram_wen", 32'(bus.ram_wen), 32'd0);
    step();
    bus.req0 = 1'b0;
    #1;
    check("p0_rvalid0", 32'(bus.rvalid0), 32'd1);
    check("p0_rdata0", bus.rdata0, 32'hDEADBEEF);
    check("p0_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("p0_rdata1", bus.rdata1, 32'h0);

    // Port 1 write then read back
    bus.req1 = 1'b1; bus.wen1 = 4'hF; bus.addr1 = 32'h20; bus.wdata1 = 32'h12345678;
    #1;
    check("p1w_gnt1", 32'(bus.gnt1), 32'd1);
    check("p1w_ram_addr", 32'(bus.ram_addr), 32'd8);
    check("p1w_ram_wdata", bus.ram_wdata, 32'h12345678);
    step();
    bus.wen1 = 4'h0;
    #1;
    check("p1w_no_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("p1r_gnt1", 32'(bus.gnt1), 32'd1);
    step();
    bus.req1 = 1'b0;
    #1;
    check("p1r_rvalid1", 32'(bus.rvalid1), 32'd1);
    check("p1r_rdata1", bus.rdata1, 32'h12345678);
    check("p1r_rvalid0", 32'(bus.rvalid0), 32'd0);

    // Starvation: both reading for 20 cycles, port 1 forced on cycles 8 and 17
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.wen0 = 4'h0;
    bus.req1 = 1'b1; bus.addr1 = 32'h20; bus.wen1 = 4'h0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("starve_gnt1_c%0d", i), 32'(bus.gnt1), 32'((i == 8) || (i == 17)));
      check($sformatf("starve_gnt0_c%0d", i), 32'(bus.gnt0), 32'(!((i == 8) || (i == 17))));
      step();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
    check("starve_conflict", 32'(conflict_cnt), 32'd20);
    check("starve_last_rvalid0", 32'(bus.rvalid0), 32'd1);
    check("starve_last_rdata0", bus.rdata0, 32'hDEADBEEF);
    step();

    // Back-to-back interleave: port0 A, port1 B, port0 C
    bus.req0 = 1'b1; bus.addr0 = 32'h40;
    #1;
    check("ilv_gnt0_a", 32'(bus.gnt0), 32'd1);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 32'h44;
    #1;
    check("ilv_gnt1_b", 32'(bus.gnt1), 32'd1);
    check("ilv_rvalid0_a", 32'(bus.rvalid0), 32'd1);
    check("ilv_rdata0_a", bus.rdata0, 32'hA0A0A0A0);
    step();
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h48;
    #1;
    check("ilv_gnt0_c", 32'(bus.gnt0), 32'd1);
    check("ilv_rvalid1_b", 32'(bus.rvalid1), 32'd1);
    check("ilv_rdata1_b", bus.rdata1, 32'hB1B1B1B1);
    check("ilv_rvalid0_b", 32'(bus.rvalid0), 32'd0);
    step();
    bus.req0 = 1'b0;
    #1;
    check("ilv_rvalid0_c", 32'(bus.rvalid0), 32'd1);
    check("ilv_rdata0_c", bus.rdata0, 32'hC2C2C2C2);
    check("ilv_rvalid1_c", 32'(bus.rvalid1), 32'd0);
    step();

    // Reset in the cycle after a port 0 read grant
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    #1;
    check("rmid_gnt0", 32'(bus.gnt0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.addr0 = 32'h40;
    #1;
    check("rmid_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rmid_rdata0", bus.rdata0, 32'h0);
    check("rmid_gnt0_held", 32'(bus.gnt0), 32'd0);
    check("rmid_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rmid_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    bus.req0 = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rmid_post_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    #1;
    check("rmid_post2_rvalid0", 32'(bus.rvalid0), 32'd0);
    bus.req0 = 1'b1; bus.addr0 = 32'h40;
    #1;
    check("rmid_resume_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    bus.req0 = 1'b0;
    #1;
    check("rmid_resume_rvalid0", 32'(bus.rvalid0), 32'd1);
    check("rmid_resume_rdata0", bus.rdata0, 32'hA0A0A0A0);
    step();

    // Idle for 5 cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("idle_ram_wen_c%0d", i), 32'(bus.ram_wen), 32'd0);
      check($sformatf("idle_gnt_c%0d", i), 32'({bus.gnt0, bus.gnt1}), 32'd0);
      check($sformatf("idle_rvalid_c%0d", i), 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters.
- Requester 0 is the CPU MEM stage, with loads and stores. Requester 1 is the debug/display port, which does reads and occasional test writes.
- Fixed priority goes to the CPU, with a bounded-starvation override for the debug port. Read data is returned with the RAM's 1-cycle latency, tagged to the requester that issued the read.
- The block sits between the MEM stage, the debug port, and the data_ram port A.

Parameters:
- ADDR_W, 32, byte address width of both requester ports.
- STARVE_LIMIT, 8, consecutive cycles that port 1 may be denied before it is forced to win.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  CPU request valid.
- wen0  in  4  CPU byte write enables; 0 means read.
- addr0  in  ADDR_W  CPU byte address.
- wdata0  in  32  CPU write data.
- gnt0  out  1  CPU request accepted this cycle.
- rvalid0  out  1  CPU read data valid.
- rdata0  out  32  CPU read data.
- req1, wen1, addr1, wdata1, gnt1, rvalid1, rdata1: same widths and meanings, for the debug port.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  8  RAM word address, taken from addr[9:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid 1 cycle after the address is presented.
- conflict_cnt  out  CNT_W  count of cycles where both requests were pending.

Behaviour:
- Handshake: a requester holds req, wen, addr and wdata stable until it sees gnt high in the same cycle. A transfer happens when req and gnt are both high. gnt is combinational from the req inputs and the registered starvation state.
- At most one grant per cycle. Back-to-back grants to either port are allowed every cycle, with no bubble.
- Arbitration:
  - force1 = (starve_cnt == STARVE_LIMIT).
  - If req1 and (force1 or not req0), then gnt1=1. Otherwise gnt0=req0.
  - Only req1 alone → gnt1. Neither request → no grant.
- RAM drive:
  - ram_addr, ram_wen and ram_wdata come from the granted port.
  - If there is no grant: ram_wen=0, ram_addr=0, ram_wdata=0.
  - Combinational path, so the RAM samples the access on the grant edge.
- Writes complete at the grant edge. There is no rvalid for a write.
- Read response:
  - Register resp_vld and resp_id, set when a granted read occurs (wen==0).
  - In the next cycle, rvalid<resp_id>=1 and rdata<resp_id>=ram_rdata.
  - For the other port, rvalid=0 and rdata=0.
  - Latency is exactly 1 cycle, in order.
- Starvation counter (starve_cnt, width ceil(log2(STARVE_LIMIT+1))):
  - Cleared when gnt1 is asserted or when req1=0.
  - Incremented when req1=1 and gnt1=0.
  - Saturates at STARVE_LIMIT.
  - When force1 fires, port 0 is denied for exactly that cycle.
- conflict_cnt increments on every cycle where req0 and req1 are both high, and saturates at all-ones.
- Same-address read and write in consecutive cycles: the RAM semantics apply (read-first on port A). The arbiter adds no forwarding.
- Reset, asynchronous, any time:
  - starve_cnt=0, resp_vld=0, resp_id=0, conflict_cnt=0.
  - All outputs read 0.
  - An in-flight read response is dropped, and no rvalid is produced after reset deasserts.
- Requester-side rules: deasserting req before the grant is legal (the request is withdrawn). Changing addr or wen while req=1 and gnt=0 is illegal and is flagged by bench assertion.

Test Plan:
- Port 0 only: read addr0=0x10 with RAM word 4 = 0xDEADBEEF → gnt0 in the same cycle, rvalid0=1 and rdata0=0xDEADBEEF one cycle later, rvalid1=0.
- Port 1 write then read: wen1=4'hF, addr1=0x20, wdata1=0x12345678, then a read of 0x20 → gnt1 on both, and rdata1=0x12345678 on the cycle after the read grant.
- Starvation: hold req0 and req1 (both reads) continuously for 20 cycles with STARVE_LIMIT=8:
  - Cycles 0–7 → gnt0.
  - Cycle 8 → gnt1.
  - Counter restarts, so the next gnt1 comes at cycle 17.
  - conflict_cnt=20.
- Back-to-back interleave: reads port0 A, port1 B, port0 C on consecutive cycles → rvalid0, rvalid1, rvalid0 on the following three cycles, with the correct data each time and no bubble.
- Reset mid-read: assert reset in the cycle after gnt0 for a read → rvalid0 stays 0, all outputs are 0, conflict_cnt=0; after release, normal grants resume.
- Idle: no requests for 5 cycles → ram_wen=0 and all gnt/rvalid low throughout.
